fib_ctrl: RTL
=============

# fib_ctrl

Sequencer for the 20-bit Fibonacci datapath (`calc`). It accepts an index request over a valid/ready handshake and drives the datapath controls `rst_ctl`, `mux` and `en` through clear, seed and iterate phases. It returns F(n) over a valid/ready response channel. It sits between the host-side request logic and one `calc` instance inside the `fib_unit` integration top.

## Interface
- DATA_W, 20, result width; must equal the datapath width
- N_W, 5, width of the requested index
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_n  in  N_W  Fibonacci index n, with F(0)=0 and F(1)=1
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DATA_W  F(n), registered
- rsp_err  out  1  index out of range; present only when `FIB_CTRL_RANGE_EN` is defined
- busy  out  1  high in every state except IDLE
- dp_rst_ctl  out  1  to `calc.rst_ctl`; clears Fn1 and Fn2
- dp_mux  out  1  to `calc.mux`; selects the seed (Fn1=1, Fn2=0)
- dp_en  out  1  to `calc.en`
- dp_result  in  DATA_W  from `calc.result`, which equals Fn1+Fn2

## Operation
- Moore FSM with states IDLE, CLEAR, LOAD, STEP, DONE, RESP. All `dp_*` outputs and `busy` decode from state only.
- Per-state outputs:
  - IDLE: req_ready=1; all `dp_*`=0.
  - CLEAR: dp_rst_ctl=1.
  - LOAD: dp_en=1, dp_mux=1.
  - STEP: dp_en=1, dp_mux=0.
  - DONE and RESP: all `dp_*`=0, so the datapath holds.
- Request handshake: a transfer occurs when req_valid && req_ready. On transfer, n is latched and IDLE moves to CLEAR.
- CLEAR transitions:
  - n=0 goes to DONE.
  - Otherwise go to LOAD.
- LOAD loads the step counter with n-2.
  - n≤2 goes to DONE.
  - Otherwise go to STEP.
- STEP decrements the counter each cycle. When the counter reaches 0 it moves to DONE, so STEP lasts exactly n-2 cycles.
- Datapath arithmetic:
  - After CLEAR, dp_result=0.
  - After LOAD, dp_result=F(2)=1, which also equals F(1).
  - After k STEP cycles, dp_result=F(k+2).
- DONE registers dp_result into rsp_data, then moves to RESP.
- RESP holds rsp_valid=1 with rsp_data stable until rsp_ready. On rsp_ready it returns to IDLE.
- Back-to-back requests: req_ready rises in the cycle after the response transfer.
- Arithmetic is modulo 2^DATA_W. No saturation is applied.
- A request never interrupts work in flight; req_ready=0 outside IDLE.

## Timing
- The transfer edge is cycle 0. rsp_valid first rises in the following cycle:
  - n=0: cycle 3
  - n=1 or n=2: cycle 4
  - n≥3: cycle n+2
  - Range error (macro on): cycle 1
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, all `dp_*`=0, counter=0.
- req_ready=1 in the reset state, but no transfer is accepted while rst is low.
- Reset asserted mid-operation: state returns to IDLE immediately (asynchronous). Any pending response is lost. The datapath is cleared by its own reset.
- rsp_ready held high continuously: the response transfers in its first RESP cycle.
- rsp_ready asserted outside RESP has no effect.

## Configuration
- `FIB_CTRL_RANGE_EN` defined:
  - An accepted request with n>30 skips the datapath and goes IDLE→RESP, with rsp_err=1 and rsp_data=0.
  - For n≤30, rsp_err=0.
  - F(30)=832040 is the largest value that fits in 20 bits.
- `FIB_CTRL_RANGE_EN` undefined:
  - The rsp_err port is absent.
  - All indices 0..31 run normally, and results wrap modulo 2^20.

## Structure
- Shared package `fib_pkg` holds:
  - the state enum `fib_state_t`
  - FIB_DATA_W=20
  - FIB_N_W=5
  - FIB_N_MAX=30
- The step counter and FSM stay in a single module; no sub-module is warranted.
- `fib_unit` instantiates `fib_ctrl` and `calc` and ties them together:
  - `dp_rst_ctl` to `rst_ctl`, `dp_mux` to `mux`, `dp_en` to `en`
  - `calc.result` to `dp_result`
  - `calc.rst` to `~rst`, since `calc` resets active-high

## Test plan
- Reset release, then n=0 with rsp_ready=1 -> rsp_data=0, rsp_valid in cycle 3, busy low afterwards.
- n=1, then n=2 back-to-back -> both return 1, each at cycle 4; req_ready low in between.
- n=10 -> rsp_data=55 at cycle 12; dp_en high for exactly 9 cycles (LOAD plus 8 STEP).
- n=30 with rsp_ready low for 5 cycles -> rsp_data=832040 held stable and rsp_valid held; transfer occurs on the rsp_ready rise.
- n=31 -> with the macro, rsp_err=1 and rsp_data=0 at cycle 1 with no dp_en pulses; without the macro, rsp_data=297693.
- n=20 with rst pulsed low in STEP -> outputs take reset values immediately; a new n=5 request afterwards returns 5.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer and its datapath.
package fib_pkg;

  localparam int FIB_DATA_W = 20;
  localparam int FIB_N_W    = 5;
  // Largest index whose value fits in FIB_DATA_W bits: F(30)=832040.
  localparam int FIB_N_MAX  = 30;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4,
    RESP  = 3'd5
  } fib_state_t;

endpackage

// File: rtl/fib_ctrl_if.sv
// Request/response channels between the host-side logic and fib_ctrl.
// rsp_err is present only when FIB_CTRL_RANGE_EN is defined.
interface fib_ctrl_if
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int N_W    = FIB_N_W
);
  logic              req_valid;
  logic              req_ready;
  logic [N_W-1:0]    req_n;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
`ifdef FIB_CTRL_RANGE_EN
  logic              rsp_err;
`endif

  // Host side: issues requests, consumes responses.
  modport master (
`ifdef FIB_CTRL_RANGE_EN
    input  rsp_err,
`endif
    output req_valid, req_n, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Controller side.
  modport slave (
`ifdef FIB_CTRL_RANGE_EN
    output rsp_err,
`endif
    input  req_valid, req_n, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fib_ctrl.sv
// Sequencer for the 20-bit Fibonacci datapath (calc): clear, seed, iterate,
// then return F(n) over a valid/ready response channel.
// Optional feature: FIB_CTRL_RANGE_EN rejects n > FIB_N_MAX with rsp_err=1.
module fib_ctrl
  import fib_pkg::*;
#(
  parameter int DATA_W = FIB_DATA_W,
  parameter int N_W    = FIB_N_W
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active low
  fib_ctrl_if.slave         bus,
  output logic              busy,
  output logic              dp_rst_ctl,
  output logic              dp_mux,
  output logic              dp_en,
  input  logic [DATA_W-1:0] dp_result
);

  fib_state_t        state_q, state_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [N_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
`ifdef FIB_CTRL_RANGE_EN
  logic              rsp_err_q, rsp_err_d;
`endif

  // State, latched index, step counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
`ifdef FIB_CTRL_RANGE_EN
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
`ifdef FIB_CTRL_RANGE_EN
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  // Next-state logic; the step counter holds n-2 on STEP entry so STEP
  // lasts exactly n-2 cycles and leaves when the decrement reaches zero.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
`ifdef FIB_CTRL_RANGE_EN
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          n_d = bus.req_n;
`ifdef FIB_CTRL_RANGE_EN
          if (bus.req_n > N_W'(FIB_N_MAX)) begin
            // Out-of-range index bypasses the datapath entirely.
            state_d    = RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d    = CLEAR;
            rsp_err_d  = 1'b0;
          end
`else
          state_d = CLEAR;
`endif
        end
      end
      CLEAR: state_d = (n_q == '0) ? DONE : LOAD;
      LOAD: begin
        cnt_d   = n_q - N_W'(2);
        state_d = (n_q <= N_W'(2)) ? DONE : STEP;
      end
      STEP: begin
        cnt_d = cnt_q - N_W'(1);
        if (cnt_q == N_W'(1)) state_d = DONE;
      end
      DONE: begin
        rsp_data_d = dp_result;
        state_d    = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs: everything decodes from the current state only.
  always_comb begin
    dp_rst_ctl = 1'b0;
    dp_mux     = 1'b0;
    dp_en      = 1'b0;
    case (state_q)
      CLEAR: dp_rst_ctl = 1'b1;
      LOAD: begin
        dp_en  = 1'b1;
        dp_mux = 1'b1;
      end
      STEP:    dp_en = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rsp_data_q;
`ifdef FIB_CTRL_RANGE_EN
  assign bus.rsp_err   = rsp_err_q;
`endif

endmodule
